tile_ram_arbiter: RTL
=====================

// Module: tile_ram_arbiter
// PURPOSE
// Shares the SB_RAM40_4K tile map (4 cells x 4 bits per 16-bit word) between two requesters:
// the VGA pixel fetch path (fixed priority, never stalled) and the game logic (valid/ready cell commands).
// Game commands are cell reads and read-modify-write nibble updates, run by a 5-state FSM.
// The arbiter owns separate BRAM read and write address buses, so writes overlap video fetches.
// PARAMETERS
// ADDR_W   8   tile map word address width (256 x 16 words)
// DATA_W   16  BRAM word width; fixed at 16, 4 cells per word
// CELL_W   4   cell code width; fixed at 4
// PORTS
// i_Clk          in   1       system clock (25 MHz pixel clock)
// i_Rst_n        in   1       asynchronous active-low reset
// i_Vid_Req      in   1       video fetch this cycle (priority requester)
// i_Vid_Addr     in   ADDR_W  video word address
// o_Vid_Data     out  DATA_W  read word for video; = i_Ram_Rdata, valid 1 cycle after i_Vid_Req
// i_Cmd_Valid    in   1       game command valid
// o_Cmd_Ready    out  1       arbiter accepts a command (registered)
// i_Cmd_Write    in   1       1 = nibble write, 0 = nibble read
// i_Cmd_Addr     in   ADDR_W  command word address
// i_Cmd_Sel      in   2       cell select: 0=[15:12], 1=[11:8], 2=[7:4], 3=[3:0]
// i_Cmd_Data     in   CELL_W  new cell code (writes only)
// o_Rsp_Valid    out  1       one-cycle pulse: command completed
// o_Rsp_Data     out  CELL_W  cell value read (for writes: the value before the write)
// o_Ram_Raddr    out  ADDR_W  BRAM RADDR
// i_Ram_Rdata    in   DATA_W  BRAM RDATA (registered read, 1-cycle latency)
// o_Ram_Waddr    out  ADDR_W  BRAM WADDR
// o_Ram_Wdata    out  DATA_W  BRAM WDATA
// o_Ram_We       out  1       BRAM WE
// BEHAVIOUR
// - Reset (i_Rst_n low, async): FSM=IDLE; o_Cmd_Ready=0, o_Rsp_Valid=0, o_Rsp_Data=0, o_Ram_We=0,
//   o_Ram_Waddr=0, o_Ram_Wdata=0, latched command cleared. o_Cmd_Ready rises the first edge after release.
// - o_Ram_Raddr (comb): the command address when state==RD_ISSUE and !i_Vid_Req; otherwise i_Vid_Addr.
// - IDLE: o_Cmd_Ready=1. When i_Cmd_Valid && o_Cmd_Ready: latch write/addr/sel/data; ready drops next cycle; go RD_ISSUE.
// - RD_ISSUE: if i_Vid_Req, hold the state (video wins, no limit). Else drive the command address on o_Ram_Raddr and go RD_WAIT.
// - RD_WAIT: capture i_Ram_Rdata into the word register and extract the selected nibble into o_Rsp_Data.
//   For a read, go RSP. For a write, go WR. RAM read port is free for video this cycle.
// - WR: write only if !(i_Vid_Req && i_Vid_Addr==cmd addr); on a collision, hold WR and retry each cycle.
//   The write cycle registers o_Ram_We=1, o_Ram_Waddr=cmd addr and o_Ram_Wdata=word with the selected nibble replaced.
//   We pulses for exactly one cycle. Go RSP.
// - RSP: o_Rsp_Valid=1 for one cycle; return to IDLE with o_Cmd_Ready=1 the following cycle.
// - Uncontended latency (accept edge to o_Rsp_Valid): 3 cycles for a read, 4 for a write.
// - Each video stall cycle adds 1. Max 1 command in flight; no queueing.
// - Non-selected nibbles are never altered; merge uses the word read in RD_WAIT.
// - No write during RD_ISSUE/RD_WAIT; WE is never asserted outside WR.
// - Reset mid-command: command dropped, no WE and no o_Rsp_Valid afterwards, BRAM unchanged if reset precedes the WR edge.
// - i_Cmd_Valid while ready is low is ignored; the requester holds its command until accepted.
// TESTING
// - Reset release: all outputs 0 during reset; o_Cmd_Ready=1 exactly 1 cycle after i_Rst_n rises; no WE.
// - Read, video idle: word[0x05]=0x1234, read sel=2 -> o_Rsp_Data=0x3, o_Rsp_Valid 3 cycles after accept.
// - Write, video idle: word[0x10]=0x0101, write sel=0 data=0x2 -> single WE with Waddr=0x10, Wdata=0x2101;
//   Rsp_Data=0x0; a following read sel=0 returns 0x2.
// - Video priority: i_Vid_Req high for 10 cycles from accept -> Raddr tracks i_Vid_Addr and o_Vid_Data is correct;
//   response arrives 3 cycles after i_Vid_Req falls.
// - Write collision: in WR, i_Vid_Addr=cmd addr for 2 cycles -> WE held off 2 cycles, then one WE; video sees the old word.
// - Reset during RD_WAIT of a write -> no WE, no o_Rsp_Valid; word unchanged; ready returns and the next command completes normally.

Source files
------------

// File: rtl/tile_ram_arbiter.sv
// Tile map BRAM arbiter: video fetch has fixed priority, game cell reads / nibble RMW writes via valid/ready.
// Latency: video data 1 cycle after request; command response 3 (read) / 4 (write) cycles plus video stalls.
// Backpressure: o_Cmd_Ready low while a command is in flight; the video path is never stalled.
module tile_ram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int CELL_W = 4
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic              i_Vid_Req,
    input  logic [ADDR_W-1:0] i_Vid_Addr,
    output logic [DATA_W-1:0] o_Vid_Data,
    input  logic              i_Cmd_Valid,
    output logic              o_Cmd_Ready,
    input  logic              i_Cmd_Write,
    input  logic [ADDR_W-1:0] i_Cmd_Addr,
    input  logic [1:0]        i_Cmd_Sel,
    input  logic [CELL_W-1:0] i_Cmd_Data,
    output logic              o_Rsp_Valid,
    output logic [CELL_W-1:0] o_Rsp_Data,
    output logic [ADDR_W-1:0] o_Ram_Raddr,
    input  logic [DATA_W-1:0] i_Ram_Rdata,
    output logic [ADDR_W-1:0] o_Ram_Waddr,
    output logic [DATA_W-1:0] o_Ram_Wdata,
    output logic              o_Ram_We
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_WR,
        S_RSP
    } state_t;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [1:0]        sel;
        logic [CELL_W-1:0] dat;
    } cmd_t;

    state_t            state_q;
    cmd_t              cmd_q;
    logic [DATA_W-1:0] word_q;
    logic              ready_q;
    logic              rsp_vld_q;
    logic [CELL_W-1:0] rsp_dat_q;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;

    logic [3:0]        cell_sh;
    logic [CELL_W-1:0] rsp_nib_d;
    logic [DATA_W-1:0] cell_mask;
    logic [DATA_W-1:0] wdata_d;
    logic              wr_hit;

    // Cell 0 sits in the top nibble, so the shift is (3 - sel) * 4.
    assign cell_sh   = {~cmd_q.sel, 2'b00};
    assign rsp_nib_d = CELL_W'(i_Ram_Rdata >> cell_sh);
    assign cell_mask = DATA_W'({CELL_W{1'b1}}) << cell_sh;
    assign wdata_d   = (word_q & ~cell_mask) | (DATA_W'(cmd_q.dat) << cell_sh);

    // A video read of the word being written is allowed to finish first.
    assign wr_hit = i_Vid_Req && (i_Vid_Addr == cmd_q.addr);

    assign o_Ram_Raddr = (state_q == S_RD_ISSUE && !i_Vid_Req) ? cmd_q.addr : i_Vid_Addr;
    assign o_Vid_Data  = i_Ram_Rdata;

    assign o_Cmd_Ready = ready_q;
    assign o_Rsp_Valid = rsp_vld_q;
    assign o_Rsp_Data  = rsp_dat_q;
    assign o_Ram_We    = we_q;
    assign o_Ram_Waddr = waddr_q;
    assign o_Ram_Wdata = wdata_q;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= S_IDLE;
            cmd_q     <= '0;
            word_q    <= '0;
            ready_q   <= 1'b0;
            rsp_vld_q <= 1'b0;
            rsp_dat_q <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            we_q      <= 1'b0;
            rsp_vld_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ready_q && i_Cmd_Valid) begin
                        cmd_q.wr   <= i_Cmd_Write;
                        cmd_q.addr <= i_Cmd_Addr;
                        cmd_q.sel  <= i_Cmd_Sel;
                        cmd_q.dat  <= i_Cmd_Data;
                        ready_q    <= 1'b0;
                        state_q    <= S_RD_ISSUE;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                S_RD_ISSUE: begin
                    if (!i_Vid_Req) begin
                        state_q <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    word_q    <= i_Ram_Rdata;
                    rsp_dat_q <= rsp_nib_d;
                    state_q   <= cmd_q.wr ? S_WR : S_RSP;
                end
                S_WR: begin
                    if (!wr_hit) begin
                        we_q    <= 1'b1;
                        waddr_q <= cmd_q.addr;
                        wdata_q <= wdata_d;
                        state_q <= S_RSP;
                    end
                end
                S_RSP: begin
                    rsp_vld_q <= 1'b1;
                    ready_q   <= 1'b1;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
